// File: rtl/cordic_req_sched.sv
// rtl/cordic_req_sched.sv - CORDIC command issuer and in-order response collector
// Optional watchdog: define CORDIC_SCHED_TIMEOUT_EN (adds the timeout port).
module cordic_req_sched #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_mode,
    input  logic [31:0] cmd_data,
    output logic [3:0]  core_mode,
    output logic [31:0] core_angle,
    output logic        core_pre_valid,
    input  logic [31:0] core_result,
    input  logic        core_post_valid,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [3:0]  rsp_mode,
    output logic        rsp_err,
`ifdef CORDIC_SCHED_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic        spurious
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int LIMIT = DEPTH - 1;
`else
    localparam int LIMIT = DEPTH;
`endif

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] outstanding, out_nx, fifo_count;
    logic [3:0]    cur_mode, err_mode;
    logic          err_pend;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [36:0]   mem [DEPTH];
    logic [36:0]   push_entry;
    logic [CW:0]   credit_used;
    logic          space, acc, mode_ok, issue, ret, push, pop, wd_fire;

    assign core_mode = cur_mode;
    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign {rsp_err, rsp_mode, rsp_data} = rsp_valid ? mem[rd_ptr] : 37'd0;

`ifdef CORDIC_SCHED_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd_cnt;

    assign wd_fire = (outstanding != '0) && !core_post_valid && (wd_cnt == WDW'(TIMEOUT - 1));
    assign timeout = wd_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (outstanding == '0 || core_post_valid || wd_fire)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = |TIMEOUT;
    assign wd_fire    = 1'b0;
`endif

    always_comb begin
        mode_ok     = (cmd_mode < 4'd10);
        // a pending error entry holds a FIFO slot just like an in-flight request
        credit_used = (CW+1)'(outstanding) + (CW+1)'(fifo_count) + (CW+1)'(err_pend);
        space       = credit_used < (CW+1)'(LIMIT);

        cmd_ready = 1'b0;
        case (state)
            IDLE:    cmd_ready = space;
            STREAM:  cmd_ready = space && (cmd_mode == cur_mode);
            default: cmd_ready = 1'b0;
        endcase
        if (!rst_n || wd_fire)
            cmd_ready = 1'b0;

        acc    = cmd_valid && cmd_ready;
        issue  = acc && mode_ok;
        ret    = core_post_valid && (outstanding != '0);
        out_nx = outstanding + CW'(issue) - CW'(ret);
        if (wd_fire)
            out_nx = '0;

        state_nx = state;
        case (state)
            IDLE:   if (issue) state_nx = STREAM;
            STREAM: begin
                if (cmd_valid && cmd_mode != cur_mode)
                    state_nx = DRAIN;
                else if (out_nx == '0 && !acc)
                    state_nx = IDLE;
            end
            DRAIN:  if (outstanding == '0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (wd_fire)
            state_nx = IDLE;

        // at most one push source is active in any cycle
        push       = err_pend || ret || wd_fire;
        push_entry = {1'b0, cur_mode, core_result};
        if (err_pend)
            push_entry = {1'b1, err_mode, 32'd0};
        if (wd_fire)
            push_entry = {1'b1, cur_mode, 32'hFFFF_FFFF};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            outstanding    <= '0;
            cur_mode       <= 4'd0;
            core_pre_valid <= 1'b0;
            core_angle     <= 32'd0;
            err_pend       <= 1'b0;
            err_mode       <= 4'd0;
            spurious       <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
        end else begin
            state          <= state_nx;
            outstanding    <= out_nx;
            core_pre_valid <= issue;
            if (issue)
                core_angle <= cmd_data;
            if (issue && state == IDLE)
                cur_mode <= cmd_mode;
            err_pend <= acc && !mode_ok;
            if (acc && !mode_ok)
                err_mode <= cmd_mode;
            spurious <= core_post_valid && (outstanding == '0);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_entry;
    end
endmodule

// File: tb/tb_cordic_req_sched.sv
// tb/tb_cordic_req_sched.sv - self-checking bench for cordic_req_sched
module tb_cordic_req_sched;
    localparam int L = 18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_mode = 4'd0;
    logic [31:0] cmd_data = 32'd0;
    logic [3:0]  core_mode;
    logic [31:0] core_angle;
    logic        core_pre_valid;
    logic [31:0] core_result;
    logic        core_post_valid;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_mode;
    logic        rsp_err;
    logic        spurious;

    cordic_req_sched #(.DEPTH(8), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_data(cmd_data),
        .core_mode(core_mode), .core_angle(core_angle), .core_pre_valid(core_pre_valid),
        .core_result(core_result), .core_post_valid(core_post_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_mode(rsp_mode), .rsp_err(rsp_err), .spurious(spurious)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [3:0] m);
        return {a[15:0], a[31:16]} ^ {28'd0, m};
    endfunction

    // fixed-latency core model; output selected by the mode present on emergence
    logic [L-1:0] pipe_v = '0;
    logic [31:0]  pipe_a [L];
    logic         inj = 1'b0;
    always @(negedge clk) begin
        pipe_v    <= {pipe_v[L-2:0], core_pre_valid};
        pipe_a[0] <= core_angle;
        for (int i = 1; i < L; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign core_post_valid = pipe_v[L-1] | inj;
    assign core_result     = core_fn(pipe_a[L-1], core_mode);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        err;
        logic [3:0]  mode;
        logic [31:0] data;
    } rsp_t;
    rsp_t expq[$];

    int   pv_cnt = 0, run = 0, max_run = 0, spur_cnt = 0;
    logic mode_chk_en = 1'b0;
    logic [3:0] last_mode = 4'd0;

    always @(negedge clk) begin
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                check("rsp_extra", 64'(rsp_valid), 64'd0);
            end else begin
                check("rsp_err",  64'(rsp_err),  64'(expq[0].err));
                check("rsp_mode", 64'(rsp_mode), 64'(expq[0].mode));
                check("rsp_data", 64'(rsp_data), 64'(expq[0].data));
                void'(expq.pop_front());
            end
        end
        if (core_pre_valid) begin
            pv_cnt++;
            run++;
            if (run > max_run) max_run = run;
        end else begin
            run = 0;
        end
        if (spurious) spur_cnt++;
        if (mode_chk_en && core_mode != last_mode)
            check("mode_change_in_flight", 64'(pipe_v[L-1:1]), 64'd0);
        last_mode = core_mode;
    end

    task automatic send(input logic [3:0] m, input logic [31:0] d, input int budget, output int waited);
        logic r;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_data  = d;
        waited    = 0;
        r         = 1'b0;
        while (!r && waited < budget) begin
            #1 r = cmd_ready;
            @(negedge clk);
            if (!r) waited++;
        end
        cmd_valid = 1'b0;
        if (!r) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (expq.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(expq.size()), 64'd0);
    endtask

    typedef struct {
        logic [3:0]  mode;
        logic [31:0] data;
        logic        err;
        logic [31:0] exp;
        int          min_wait;
        int          max_wait;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int w, sbase, pbase;
        tbl[0] = '{4'd0, 32'h0000_0000, 1'b0, 32'h0000_0000, 0, 0};
        tbl[1] = '{4'd0, 32'h0000_4000, 1'b0, 32'h4000_0000, 0, 0};
        tbl[2] = '{4'd0, 32'h0000_8000, 1'b0, 32'h8000_0000, 0, 0};
        tbl[3] = '{4'd0, 32'h0000_C000, 1'b0, 32'hC000_0000, 0, 0};
        tbl[4] = '{4'd1, 32'h0001_0002, 1'b0, 32'h0002_0000, 18, 30};
        tbl[5] = '{4'hC, 32'h0000_1234, 1'b1, 32'h0000_0000, 18, 30};
        tbl[6] = '{4'd9, 32'hDEAD_BEEF, 1'b0, 32'hBEEF_DEA4, 0, 0};
        tbl[7] = '{4'd3, 32'h1234_5678, 1'b0, 32'h5678_1237, 18, 30};

        // reset state
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_pre_valid", 64'(core_pre_valid), 64'd0);
        check("rst_core_mode", 64'(core_mode), 64'd0);
        check("rst_core_angle", 64'(core_angle), 64'd0);
        check("rst_spurious", 64'(spurious), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mode_chk_en = 1'b1;
        @(negedge clk);

        // table: back-to-back stream, mode change, invalid in stream, more changes
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            expq.push_back('{tbl[i].err, tbl[i].mode, tbl[i].exp});
            send(tbl[i].mode, tbl[i].data, 60, w);
            check($sformatf("wait_min_%0d", i), 64'(w >= tbl[i].min_wait), 64'd1);
            check($sformatf("wait_max_%0d", i), 64'(w <= tbl[i].max_wait), 64'd1);
        end
        wait_drain("table_drain", 100);
        check("table_pv_cnt", 64'(pv_cnt), 64'd7);
        check("table_max_run", 64'(max_run), 64'd4);

        // invalid mode in IDLE: immediate error entry, no issue
        rsp_ready = 1'b0;
        pbase = pv_cnt;
        send(4'hC, 32'h0000_1234, 10, w);
        check("inv_wait", 64'(w), 64'd0);
        @(negedge clk);
        #1;
        check("inv_rsp_valid", 64'(rsp_valid), 64'd1);
        check("inv_rsp_err", 64'(rsp_err), 64'd1);
        check("inv_rsp_mode", 64'(rsp_mode), 64'hC);
        check("inv_rsp_data", 64'(rsp_data), 64'd0);
        check("inv_no_issue", 64'(pv_cnt - pbase), 64'd0);
        expq.push_back('{1'b1, 4'hC, 32'd0});
        rsp_ready = 1'b1;
        wait_drain("inv_drain", 20);

        // backpressure: 8 credits only, then resume
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expq.push_back('{1'b0, 4'd2, 32'(i) ^ 32'd2});
            send(4'd2, 32'(i) << 16, 10, w);
            check($sformatf("bp_wait_%0d", i), 64'(w), 64'd0);
        end
        cmd_valid = 1'b1;
        cmd_mode  = 4'd2;
        cmd_data  = 32'd8 << 16;
        repeat (30) @(negedge clk);
        #1;
        check("bp_full_block", 64'(cmd_ready), 64'd0);
        check("bp_full_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        for (int i = 8; i < 12; i++) begin
            expq.push_back('{1'b0, 4'd2, 32'(i) ^ 32'd2});
            send(4'd2, 32'(i) << 16, 40, w);
        end
        wait_drain("bp_drain", 100);

        // spurious return with nothing outstanding
        @(negedge clk);
        sbase = spur_cnt;
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        #1;
        check("spur_pulse", 64'(spurious), 64'd1);
        check("spur_no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        #1;
        check("spur_one_cycle", 64'(spurious), 64'd0);
        check("spur_count", 64'(spur_cnt - sbase), 64'd1);

        // reset with 2 buffered and 3 in flight
        rsp_ready = 1'b0;
        send(4'd0, 32'h1, 10, w);
        send(4'd0, 32'h2, 10, w);
        repeat (25) @(negedge clk);
        send(4'd0, 32'h3, 10, w);
        send(4'd0, 32'h4, 10, w);
        send(4'd0, 32'h5, 10, w);
        repeat (2) @(negedge clk);
        #1;
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        mode_chk_en = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_outputs", {cmd_ready, core_pre_valid, core_mode, rsp_valid, rsp_err, rsp_mode, spurious},
              64'd0);
        check("arst_angle", 64'(core_angle), 64'd0);
        check("arst_data", 64'(rsp_data), 64'd0);
        expq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sbase = spur_cnt;
        repeat (25) @(negedge clk);
        #3;
        check("late_spurious", 64'(spur_cnt - sbase), 64'd3);
        check("late_no_rsp", 64'(rsp_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cordic_req_sched.md
Name: cordic_req_sched

Overview:
- Host-facing issuer and collector for the multi-function CORDIC top. It accepts mode/operand commands over valid/ready and drives the core's mode, operand and pre_valid.
- Returned results are captured into an in-order response FIFO.
- The core selects its output by the mode present when each result emerges and has no backpressure. This block therefore locks the mode while requests are in flight and issues only against guaranteed FIFO space.

Parameters:
- DEPTH, 8, response FIFO entries and maximum outstanding-plus-buffered results; power of 2, ≥2.
- TIMEOUT, 64, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_mode  in  4  function code: 0 sin, 1 cos, 2 arctan, 3 sinh, 4 cosh, 5 arctanh, 6 arcsin, 7 arccos, 8 ln, 9 exp
- cmd_data  in  32  signed Q16.16 operand
- core_mode  out  4  mode to core
- core_angle  out  32  operand to core
- core_pre_valid  out  1  issue strobe to core
- core_result  in  32  core result
- core_post_valid  in  1  core result strobe
- rsp_valid  out  1  FIFO non-empty
- rsp_ready  in  1  host pops when valid&ready
- rsp_data  out  32  result; 0 on error
- rsp_mode  out  4  mode of this response
- rsp_err  out  1  command had an invalid mode
- spurious  out  1  one-cycle pulse: core_post_valid seen with no request outstanding

Behaviour:
- Reset (async, rst_n=0): all registered outputs 0, FIFO empty, outstanding=0, state IDLE, cur_mode=0. cmd_ready=0 while rst_n=0.
- State registers:
  - outstanding counts issued requests not yet returned (width clog2(DEPTH+1)); an issue strobe still in its output register counts as outstanding.
  - space = (outstanding + fifo_count) < DEPTH.
- FSM states:
  - IDLE: outstanding==0.
    - cmd_ready=space.
    - Valid mode accepted: cur_mode<=cmd_mode, go STREAM.
    - Invalid mode (≥10) accepted: push {err=1, mode=cmd_mode, data=0} into the FIFO the next cycle; no issue; stay IDLE.
  - STREAM: cmd_ready = space && cmd_mode==cur_mode.
    - cmd_valid with cmd_mode≠cur_mode: go DRAIN.
    - outstanding reaches 0 with no accept that cycle: go IDLE.
  - DRAIN: cmd_ready=0. Go IDLE when outstanding==0.
- Issue timing:
  - On accept of a valid mode, on the next cycle core_pre_valid=1 for exactly one cycle and core_angle=cmd_data.
  - core_angle holds its value otherwise.
  - core_mode=cur_mode, registered. It changes only while outstanding==0, never with results in flight.
- Return path:
  - core_post_valid with outstanding>0: push {0, cur_mode, core_result}, outstanding−1.
  - Issue and return in the same cycle leave outstanding unchanged.
  - core_post_valid with outstanding==0: drop it and pulse spurious; FIFO unchanged.
- FIFO:
  - Show-ahead: rsp_* reflect the head entry.
  - Push and pop in the same cycle are allowed at any occupancy, including full with pop.
  - Overflow is impossible by the credit rule. Responses stay in command order.
- Throughput: one command per cycle while the mode is unchanged and space holds.

Optional Feature:
- Macro CORDIC_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles with outstanding>0 and no core_post_valid; any return resets the count.
  - On reaching TIMEOUT: push one {err=1, mode=cur_mode, data=32'hFFFFFFFF} entry, clear outstanding to 0, go IDLE.
  - Adds output port timeout (1-bit pulse on that cycle).
  - Credit reserves one entry (space = outstanding+fifo_count < DEPTH−1) so the error push cannot overflow.
- Undefined: no watchdog, no timeout port, credit rule as above.

Test Plan:
- Core model with fixed 18-cycle latency. Send 4 mode-0 commands, data 0x0, 0x4000, 0x8000, 0xC000, back-to-back → core_pre_valid high 4 consecutive cycles, core_mode=0 throughout, 4 responses in order with rsp_mode=0, rsp_err=0, data equal to the model's.
- Mode-1 command immediately after a mode-0 command → cmd_ready low for the mode-1 command until the mode-0 result returns; core_mode changes 0→1 only when outstanding=0; both responses in order.
- Invalid mode 4'hC, data 0x1234, in IDLE → accepted, no core_pre_valid, next cycle rsp_valid=1, rsp_err=1, rsp_mode=C, rsp_data=0.
- rsp_ready=0, 12 mode-2 commands, DEPTH=8 → exactly 8 accepted, then cmd_ready=0; raise rsp_ready → remaining 4 accepted, 12 responses in order, no loss.
- core_post_valid pulsed with nothing outstanding → spurious pulses one cycle, rsp_valid stays 0.
- Assert rst_n=0 with 3 requests in flight and 2 buffered → all outputs 0, FIFO empty. After release, late core_post_valid pulses produce spurious only.
